// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor
//
// Run-control and state-dump block for the single-cycle CPU (sccomp).
// Once armed, the CPU runs with one instruction retiring per cycle while
// cpu_run is high. It halts when the retired count reaches cfg_stop_cnt or
// when the PC matches an enabled breakpoint. After the halt, a snapshot is
// streamed out over a valid/ready port: three header beats, the register
// file, and then data memory.
//
// Ports:
//   clk, rstn            clock (rising edge) and asynchronous active-low reset
//   arm                  start pulse, sampled in IDLE and DONE only
//   cfg_stop_cnt         halt after this many retirements
//   cfg_bp_en, cfg_bp_pc PC breakpoint enable and address
//   pc_in, instr_in      current CPU PC and instruction
//   cpu_run              CPU clock enable
//   rf_raddr, rf_rdata   debug read port into the register file
//   dm_raddr, dm_rdata   debug read port into data memory
//   dump_valid/ready     snapshot stream handshake
//   dump_data/kind/last  beat payload, kind (0 hdr, 1 reg, 2 mem), final beat
//   halt_cause           bit0 count reached, bit1 breakpoint hit
//   done                 snapshot fully transferred
module cpu_run_monitor #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 16,
    parameter int NREG     = 32,
    parameter int DM_WORDS = 128,
    parameter int RIDX_W   = (NREG > 1) ? $clog2(NREG) : 1,
    parameter int DIDX_W   = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              arm,
    input  logic [CNT_W-1:0]  cfg_stop_cnt,
    input  logic              cfg_bp_en,
    input  logic [ADDR_W-1:0] cfg_bp_pc,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instr_in,
    output logic              cpu_run,
    output logic [RIDX_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [DIDX_W-1:0] dm_raddr,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [1:0]        dump_kind,
    output logic              dump_last,
    output logic [1:0]        halt_cause,
    output logic              done
);

    // The shared beat index must cover the header (0..2), the register file
    // and data memory, so it takes the widest of the three.
    localparam int IDX_W0 = (RIDX_W > DIDX_W) ? RIDX_W : DIDX_W;
    localparam int IDX_W  = (IDX_W0 > 2) ? IDX_W0 : 2;

    localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(2);
    localparam logic [IDX_W-1:0] RF_LAST  = IDX_W'(NREG - 1);
    localparam logic [IDX_W-1:0] DM_LAST  = IDX_W'(DM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_HDR,
        S_RF,
        S_DM,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        cause_q, cause_d;
    logic [ADDR_W-1:0] cap_pc_q, cap_pc_d;
    logic [DATA_W-1:0] cap_instr_q, cap_instr_d;
    logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;

    logic              halt_cnt;
    logic              halt_bp;
    logic [DATA_W-1:0] pc_ext;
    logic [DATA_W-1:0] cnt_ext;

    // Halt conditions are evaluated live against the current PC, so a
    // breakpoint stops the CPU before the matching instruction retires.
    assign halt_cnt = (count_q == cfg_stop_cnt);
    assign halt_bp  = cfg_bp_en && (pc_in == cfg_bp_pc);

    // Captured PC and count are fitted to the dump word width.
    generate
        if (ADDR_W >= DATA_W) begin : g_pc_trunc
            assign pc_ext = cap_pc_q[DATA_W-1:0];
        end else begin : g_pc_zext
            assign pc_ext = {{(DATA_W - ADDR_W){1'b0}}, cap_pc_q};
        end
        if (CNT_W >= DATA_W) begin : g_cnt_trunc
            assign cnt_ext = cap_cnt_q[DATA_W-1:0];
        end else begin : g_cnt_zext
            assign cnt_ext = {{(DATA_W - CNT_W){1'b0}}, cap_cnt_q};
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            cause_q     <= '0;
            cap_pc_q    <= '0;
            cap_instr_q <= '0;
            cap_cnt_q   <= '0;
        end else begin
            state       <= state_next;
            count_q     <= count_d;
            idx_q       <= idx_d;
            cause_q     <= cause_d;
            cap_pc_q    <= cap_pc_d;
            cap_instr_q <= cap_instr_d;
            cap_cnt_q   <= cap_cnt_d;
        end
    end

    // Next-state and output logic. In the dump states the index only moves
    // on an accepted beat; since the CPU is frozen, holding the index keeps
    // the payload stable while the consumer stalls.
    always_comb begin
        state_next  = state;
        count_d     = count_q;
        idx_d       = idx_q;
        cause_d     = cause_q;
        cap_pc_d    = cap_pc_q;
        cap_instr_d = cap_instr_q;
        cap_cnt_d   = cap_cnt_q;

        cpu_run     = 1'b0;
        rf_raddr    = '0;
        dm_raddr    = '0;
        dump_valid  = 1'b0;
        dump_data   = '0;
        dump_kind   = 2'd0;
        dump_last   = 1'b0;
        done        = 1'b0;

        case (state)
            S_IDLE: begin
                if (arm) begin
                    state_next = S_RUN;
                    count_d    = '0;
                    cause_d    = '0;
                end
            end

            S_RUN: begin
                cpu_run = !(halt_cnt || halt_bp);
                if (cpu_run) begin
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    cap_pc_d    = pc_in;
                    cap_instr_d = instr_in;
                    cap_cnt_d   = count_q;
                    cause_d     = {halt_bp, halt_cnt};
                    idx_d       = '0;
                    state_next  = S_HDR;
                end
            end

            S_HDR: begin
                dump_valid = 1'b1;
                dump_kind  = 2'd0;
                case (idx_q)
                    IDX_W'(0): dump_data = pc_ext;
                    IDX_W'(1): dump_data = cap_instr_q;
                    default:   dump_data = cnt_ext;
                endcase
                if (dump_ready) begin
                    if (idx_q == HDR_LAST) begin
                        idx_d      = '0;
                        state_next = S_RF;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_RF: begin
                dump_valid = 1'b1;
                dump_kind  = 2'd1;
                rf_raddr   = idx_q[RIDX_W-1:0];
                // Register 0 is architecturally zero regardless of storage.
                dump_data  = (idx_q == '0) ? '0 : rf_rdata;
                if (dump_ready) begin
                    if (idx_q == RF_LAST) begin
                        idx_d      = '0;
                        state_next = S_DM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_DM: begin
                dump_valid = 1'b1;
                dump_kind  = 2'd2;
                dm_raddr   = idx_q[DIDX_W-1:0];
                dump_data  = dm_rdata;
                dump_last  = (idx_q == DM_LAST);
                if (dump_ready) begin
                    if (idx_q == DM_LAST) begin
                        idx_d      = '0;
                        state_next = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_DONE: begin
                done = 1'b1;
                // Re-arming resumes the frozen CPU; it is not reset here.
                if (arm) begin
                    state_next = S_RUN;
                    count_d    = '0;
                    cause_d    = '0;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign halt_cause = cause_q;

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Synthesizable run-control and state-dump block for the single-cycle CPU (sccomp).
- Gates CPU execution, counts retired instructions, and halts on a programmable instruction count or a PC breakpoint.
- After a halt, streams a snapshot over a valid/ready port: header, register file, then data memory.
- Lets end-of-run state capture work on hardware as well as in simulation, with configurable depth and width.

Parameters:
DATA_W, 32, width of register/memory words and dump_data
ADDR_W, 32, PC width
CNT_W, 16, retired-instruction counter width
NREG, 32, register-file entries dumped (index width RIDX_W = clog2(NREG))
DM_WORDS, 128, data-memory words dumped (index width DIDX_W = clog2(DM_WORDS))

Ports:
clk  in  1  system clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
arm  in  1  start pulse; sampled in IDLE and DONE only
cfg_stop_cnt  in  CNT_W  halt after this many retirements
cfg_bp_en  in  1  enable PC breakpoint
cfg_bp_pc  in  ADDR_W  breakpoint PC
pc_in  in  ADDR_W  current CPU PC
instr_in  in  DATA_W  current CPU instruction
cpu_run  out  1  CPU clock-enable; one instruction retires per cycle while high
rf_raddr  out  RIDX_W  debug read address into register file
rf_rdata  in  DATA_W  combinational register read data
dm_raddr  out  DIDX_W  word address into data memory
dm_rdata  in  DATA_W  combinational memory read data
dump_valid  out  1  dump beat valid
dump_ready  in  1  consumer accepts beat
dump_data  out  DATA_W  beat payload
dump_kind  out  2  0 header, 1 register, 2 memory
dump_last  out  1  final beat of snapshot
halt_cause  out  2  bit0 count reached, bit1 breakpoint hit
done  out  1  snapshot fully transferred

Behaviour:
- Reset (async, rstn=0):
  - state IDLE; counter, index, halt_cause, captured PC/instr all 0.
  - cpu_run=0, dump_valid=0, dump_last=0, done=0.
  - Reset at any point, including mid-dump, aborts to IDLE; no partial beat completes.
- States: IDLE, RUN, HDR, RF, DM, DONE.
- IDLE: cpu_run=0. arm=1 -> RUN with counter cleared.
- RUN:
  - halt_cnt = (counter == cfg_stop_cnt).
  - halt_bp = cfg_bp_en && (pc_in == cfg_bp_pc).
  - cpu_run = !(halt_cnt || halt_bp), combinational, so the breakpoint instruction does NOT execute.
  - While cpu_run=1: counter increments each cycle, saturating at all-ones.
  - On a halt cycle:
    - capture pc_in, instr_in, counter;
    - halt_cause = {halt_bp, halt_cnt}; both bits set if both conditions are true;
    - go to HDR with index 0.
  - cfg_stop_cnt=0 halts on the first RUN cycle with count 0.
- Dump, all states: dump_valid=1; a beat transfers when dump_valid && dump_ready.
  - Index advances only on a transfer.
  - dump_data/kind/last stay stable while stalled; this holds because the CPU is frozen and the index is held.
- HDR: 3 beats, kind 0, in order: captured PC (zero-extended/truncated to DATA_W), captured instr, captured count (zero-extended).
  - After beat 2 -> RF, index 0.
- RF: NREG beats, kind 1.
  - rf_raddr = index; dump_data = rf_rdata, except index 0 forced to 0.
  - After index NREG-1 -> DM, index 0.
- DM: DM_WORDS beats, kind 2.
  - dm_raddr = index; dump_data = dm_rdata.
  - dump_last=1 on index DM_WORDS-1; that transfer -> DONE.
- Beat total: 3+NREG+DM_WORDS (163 at defaults).
- DONE:
  - done=1, dump_valid=0, cpu_run=0; halt_cause held.
  - arm=1 -> RUN: counter cleared, done cleared, halt_cause cleared. CPU resumes from its frozen PC; the CPU is not reset.
- Outside dump states: rf_raddr=0, dm_raddr=0, dump_data=0, dump_kind=0.
- arm ignored in RUN/HDR/RF/DM.
- cfg_* sampled live in RUN only; changes during a dump have no effect.

Test Plan:
- Count stop: cfg_stop_cnt=10, bp off, arm -> exactly 10 cycles of cpu_run=1.
  - Header beats are PC=0x28 (sequential program), instr at 0x28, count 10.
  - halt_cause=01; 163 beats total; dump_last on beat 163; done=1.
- Breakpoint: cfg_stop_cnt=100, bp_en=1, bp_pc=0x14 -> halt with 5 retirements.
  - Header PC=0x14, count=5, halt_cause=10; instruction at 0x14 not executed (its destination register is unchanged in the RF beats).
- Simultaneous/zero: cfg_stop_cnt=5 with bp_pc=0x14 -> halt_cause=11.
  - cfg_stop_cnt=0 -> cpu_run never high, header count=0.
- Backpressure: drop dump_ready randomly 50%.
  - Beat payloads match the no-stall run word for word.
  - Data stays stable while stalled; register beat 0 = 0; memory beats equal the preloaded dmem.
- Reset mid-dump: assert rstn=0 during RF index 7.
  - All outputs return to reset values immediately; after release, state is IDLE; arm starts a fresh run.
- Re-arm: from DONE, arm with cfg_stop_cnt=3.
  - CPU resumes from its frozen PC; halts 3 instructions later; new header count=3; done pulses low then high.
